// File: rtl/dac_seg_sched.sv
// Per-frame segment scheduler: on an accepted frame it runs header, body and memory
// sources in fixed order, one go pulse per source, guarded by a per-segment watchdog.
module dac_seg_sched #(
    parameter int unsigned WD_W        = 16,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   frame_tx,
    input  logic                   abort,
    input  logic [2:0]             seg_en,
    input  logic [WD_W-1:0]        wd_limit,
    input  logic                   clr_err,
    input  logic                   hdr_done,
    input  logic                   body_done,
    input  logic                   mem_done,
    output logic                   hdr_go,
    output logic                   body_go,
    output logic                   mem_go,
    output logic [1:0]             src_sel,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic                   timeout
);

    // The state encoding doubles as the output mux select and is the visible FSM state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2,
        S_MEM  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             en_q, en_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]             go_q, go_d;
    logic                   ov_q, ov_d;
    logic                   to_q, to_d;
    logic                   fd_q, fd_d;
    logic                   busy_q, busy_d;
    logic                   enter;
    logic                   seg_done;
    logic                   ov_set;
    logic                   to_set;

    // First enabled segment strictly after 'from' in hdr->body->mem order, else IDLE.
    function automatic state_t next_seg(input state_t from, input logic [2:0] en);
        state_t nxt;
        nxt = S_IDLE;
        if (en[2] && (from < S_MEM))  nxt = S_MEM;
        if (en[1] && (from < S_BODY)) nxt = S_BODY;
        if (en[0] && (from < S_HDR))  nxt = S_HDR;
        return nxt;
    endfunction

    // Source handshake: go is a one-cycle start pulse on segment entry; the source
    // answers with a one-cycle done on its last valid cycle. A done from any source
    // other than the active one is dropped.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        fd_d    = 1'b0;
        ov_set  = 1'b0;
        to_set  = 1'b0;

        seg_done = ((state_q == S_HDR)  && hdr_done)  ||
                   ((state_q == S_BODY) && body_done) ||
                   ((state_q == S_MEM)  && mem_done);

        if (abort) begin
            state_d = S_IDLE;
            wd_d    = '0;
        end else if (state_q == S_IDLE) begin
            if (frame_tx && (seg_en != 3'b000)) begin
                en_d    = seg_en;
                cnt_d   = cnt_q + 1'b1;
                state_d = next_seg(S_IDLE, seg_en);
                enter   = 1'b1;
                wd_d    = '0;
            end
        end else begin
            ov_set = frame_tx;
            if (seg_done) begin
                state_d = next_seg(state_q, en_q);
                wd_d    = '0;
                enter   = (state_d != S_IDLE);
                fd_d    = (state_d == S_IDLE);
            end else if ((wd_limit != '0) && (wd_q == wd_limit)) begin
                state_d = S_IDLE;
                wd_d    = '0;
                to_set  = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        // A new error event wins over a simultaneous clear.
        ov_d   = ov_set | (ov_q & ~clr_err);
        to_d   = to_set | (to_q & ~clr_err);
        go_d   = enter ? {state_d == S_MEM, state_d == S_BODY, state_d == S_HDR} : 3'b000;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            en_q    <= 3'b000;
            wd_q    <= '0;
            cnt_q   <= '0;
            go_q    <= 3'b000;
            ov_q    <= 1'b0;
            to_q    <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            ov_q    <= ov_d;
            to_q    <= to_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
        end
    end

    assign hdr_go     = go_q[0];
    assign body_go    = go_q[1];
    assign mem_go     = go_q[2];
    assign src_sel    = state_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign frame_cnt  = cnt_q;
    assign overrun    = ov_q;
    assign timeout    = to_q;

endmodule
